// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master system bus arbiter: field positions,
// response codes, slave ids, FSM states and the per-master request payload.
package bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned RESP_W = 2;

    // HADDR field layout
    localparam int unsigned TRANS_BIT = 15;
    localparam int unsigned SID_HI    = 14;
    localparam int unsigned SID_LO    = 13;
    localparam int unsigned WRITE_BIT = 12;
    localparam int unsigned WADDR_HI  = 10;
    localparam int unsigned WADDR_LO  = 0;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10
    } resp_e;

    localparam logic [1:0] SID_S0  = 2'b00;
    localparam logic [1:0] SID_S1  = 2'b01;
    localparam logic [1:0] SID_S2  = 2'b10;
    localparam logic [1:0] SID_BAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    typedef struct packed {
        logic              req;
        logic              lock;
        logic [ADDR_W-1:0] haddr;
        logic [DATA_W-1:0] hwdata;
    } mst_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared memory slaves.
// The arbiter sits on the master modport; the environment uses the slave modport.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic              M0_REQ;
    logic              M0_LOCK;
    logic [ADDR_W-1:0] M0_HADDR;
    logic [DATA_W-1:0] M0_HWDATA;
    logic              M1_REQ;
    logic              M1_LOCK;
    logic [ADDR_W-1:0] M1_HADDR;
    logic [DATA_W-1:0] M1_HWDATA;
    logic              M0_GNT;
    logic              M1_GNT;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic              MLOCK;
    logic [SEL_W-1:0]  SEL;
    logic              HREADY;
    logic [RESP_W-1:0] HRESP;
    logic              M_HREADY;
    logic [RESP_W-1:0] M_HRESP;

    modport master (
        input  M0_REQ, M0_LOCK, M0_HADDR, M0_HWDATA,
        input  M1_REQ, M1_LOCK, M1_HADDR, M1_HWDATA,
        input  HREADY, HRESP,
        output M0_GNT, M1_GNT, HADDR, HWDATA, MLOCK, SEL, M_HREADY, M_HRESP
    );

    modport slave (
        output M0_REQ, M0_LOCK, M0_HADDR, M0_HWDATA,
        output M1_REQ, M1_LOCK, M1_HADDR, M1_HWDATA,
        output HREADY, HRESP,
        input  M0_GNT, M1_GNT, HADDR, HWDATA, MLOCK, SEL, M_HREADY, M_HRESP
    );

endinterface

// File: rtl/bus_arbiter_addr_decoder.sv
// Slave select decode from {TRANS, slave id}; id 11 selects nothing and,
// for an active transfer, flags a decode error.
module bus_arbiter_addr_decoder
    import bus_arbiter_pkg::*;
(
    input  logic [2:0]       trans_sid,
    input  logic             en,
    output logic [SEL_W-1:0] sel_c,
    output logic             decode_err_c
);

    always_comb begin
        sel_c        = '0;
        decode_err_c = 1'b0;
        if (en) begin
            case (trans_sid[1:0])
                SID_S0:  sel_c = 3'b001;
                SID_S1:  sel_c = 3'b010;
                SID_S2:  sel_c = 3'b100;
                default: decode_err_c = trans_sid[2];
            endcase
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with lock, address decode, and
// ready-timeout / retry-limit abort so a stuck slave cannot hang the bus.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned CNT_W     = 5
) (
    input  logic          CLK,
    input  logic          RST,
    bus_arbiter_if.master bus
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

    mst_req_t         m0, m1, own;
    logic             pick_c;
    logic             hready_ok_c;
    logic             rdy_eff_c;
    logic             retry_c;
    logic             timeout_c;
    logic             retry_lim_c;
    logic             decode_err_c;
    logic [SEL_W-1:0] sel_c;

    always_comb begin
        m0  = '{req: bus.M0_REQ, lock: bus.M0_LOCK, haddr: bus.M0_HADDR, hwdata: bus.M0_HWDATA};
        m1  = '{req: bus.M1_REQ, lock: bus.M1_LOCK, haddr: bus.M1_HADDR, hwdata: bus.M1_HWDATA};
        own = owner_q ? m1 : m0;
    end

    bus_arbiter_addr_decoder u_dec (
        .trans_sid    (own.haddr[TRANS_BIT:SID_LO]),
        .en           (state_q == ST_OWN),
        .sel_c        (sel_c),
        .decode_err_c (decode_err_c)
    );

    // A floating or unknown HREADY counts as not ready; a decode error is answered locally.
    always_comb begin
        hready_ok_c = (bus.HREADY === 1'b1);
        rdy_eff_c   = decode_err_c | hready_ok_c;
        retry_c     = !decode_err_c && (bus.HRESP == RESP_RETRY);
        timeout_c   = !rdy_eff_c && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
        retry_lim_c = retry_c && !own.lock && (retry_cnt_q == CNT_W'(MAX_RETRY - 1));
        pick_c      = (m0.req && m1.req) ? !rr_last_q : m1.req;
    end

    // Next state: grant, ownership hold/release and abort
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        wait_cnt_d  = '0;
        retry_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (m0.req || m1.req) begin
                    owner_d   = pick_c;
                    rr_last_d = pick_c;
                    state_d   = ST_OWN;
                end
            end
            ST_OWN: begin
                if (timeout_c || retry_lim_c) begin
                    state_d = ST_ABORT;
                end else if (!own.req && !own.lock) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d  = rdy_eff_c ? '0 : wait_cnt_q + CNT_W'(1);
                    retry_cnt_d = retry_c ? retry_cnt_q + CNT_W'(1) : '0;
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus and owner-side outputs; everything is quiet outside OWN except the abort response
    always_comb begin
        bus.M0_GNT   = 1'b0;
        bus.M1_GNT   = 1'b0;
        bus.HADDR    = '0;
        bus.HWDATA   = '0;
        bus.MLOCK    = 1'b0;
        bus.SEL      = '0;
        bus.M_HRESP  = RESP_OKAY;
        bus.M_HREADY = 1'b0;
        case (state_q)
            ST_OWN: begin
                bus.M0_GNT   = !owner_q;
                bus.M1_GNT   = owner_q;
                bus.HADDR    = own.haddr;
                bus.HWDATA   = own.hwdata;
                bus.MLOCK    = own.lock;
                bus.SEL      = sel_c;
                bus.M_HRESP  = decode_err_c ? RESP_ERROR : bus.HRESP;
                bus.M_HREADY = rdy_eff_c;
            end
            ST_ABORT: begin
                bus.M_HRESP  = RESP_ERROR;
                bus.M_HREADY = 1'b1;
            end
            default: ;
        endcase
    end

    // rr_last resets to master 1 so master 0 wins the first contested grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            wait_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level ownership model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned MAX_RETRY = 4;
    localparam int unsigned CNT_W     = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: who owns the bus (-1 none), pending abort-response cycle, last winner,
    // consecutive not-ready and consecutive RETRY counts of the current tenure.
    int m_owner;
    bit m_abort;
    bit m_last;
    int m_wait;
    int m_retry;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        m_owner = -1; m_abort = 1'b0; m_last = 1'b1; m_wait = 0; m_retry = 0;
    endfunction

    function automatic logic [15:0] own_addr();
        return (m_owner == 1) ? bus.M1_HADDR : bus.M0_HADDR;
    endfunction

    function automatic bit own_bad();
        logic [15:0] a;
        a = own_addr();
        return a[15] && (a[14:13] == 2'b11);
    endfunction

    function automatic logic [56:0] obs_vec();
        return {bus.M0_GNT, bus.M1_GNT, bus.SEL, bus.HADDR, bus.HWDATA, bus.MLOCK, bus.M_HRESP, bus.M_HREADY};
    endfunction

    function automatic logic [56:0] exp_vec();
        logic [15:0] a;
        logic [31:0] d;
        logic        l;
        logic [2:0]  sel;
        logic [1:0]  resp;
        logic        rdy;
        if (m_abort) return {2'b00, 3'b000, 16'h0, 32'h0, 1'b0, 2'b01, 1'b1};
        if (m_owner < 0) return 57'd0;
        a   = own_addr();
        d   = (m_owner == 1) ? bus.M1_HWDATA : bus.M0_HWDATA;
        l   = (m_owner == 1) ? bus.M1_LOCK : bus.M0_LOCK;
        sel = (a[14:13] == 2'b11) ? 3'b000 : 3'(1 << a[14:13]);
        if (own_bad()) begin resp = 2'b01; rdy = 1'b1; end
        else begin resp = bus.HRESP; rdy = (bus.HREADY === 1'b1); end
        return {m_owner == 0, m_owner == 1, sel, a, d, l, resp, rdy};
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    function automatic void model_step();
        bit r0, r1, req, lock, ready_eff, retry;
        r0 = bus.M0_REQ; r1 = bus.M1_REQ;
        if (m_abort) begin m_abort = 1'b0; return; end
        if (m_owner < 0) begin
            if (r0 || r1) begin
                m_owner = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
                m_last  = (m_owner == 1);
                m_wait  = 0; m_retry = 0;
            end
            return;
        end
        req       = (m_owner == 1) ? bus.M1_REQ : bus.M0_REQ;
        lock      = (m_owner == 1) ? bus.M1_LOCK : bus.M0_LOCK;
        ready_eff = own_bad() || (bus.HREADY === 1'b1);
        retry     = !own_bad() && (bus.HRESP == 2'b10);
        if ((!ready_eff && m_wait == TIMEOUT - 1) || (retry && !lock && m_retry == MAX_RETRY - 1)) begin
            m_abort = 1'b1; m_owner = -1; m_wait = 0; m_retry = 0;
        end else if (!req && !lock) begin
            m_owner = -1; m_wait = 0; m_retry = 0;
        end else begin
            m_wait  = ready_eff ? 0 : m_wait + 1;
            m_retry = retry ? m_retry + 1 : 0;
        end
    endfunction

    task automatic idle_inputs();
        bus.M0_REQ = 1'b0; bus.M0_LOCK = 1'b0; bus.M0_HADDR = '0; bus.M0_HWDATA = '0;
        bus.M1_REQ = 1'b0; bus.M1_LOCK = 1'b0; bus.M1_HADDR = '0; bus.M1_HWDATA = '0;
        bus.HREADY = 1'b1; bus.HRESP = RESP_OKAY;
    endtask

    task automatic set_master(input int m, input bit req, input bit lock,
                              input logic [15:0] a, input logic [31:0] d);
        if (m == 0) begin bus.M0_REQ = req; bus.M0_LOCK = lock; bus.M0_HADDR = a; bus.M0_HWDATA = d; end
        else        begin bus.M1_REQ = req; bus.M1_LOCK = lock; bus.M1_HADDR = a; bus.M1_HWDATA = d; end
    endtask

    function automatic logic [15:0] rand_addr(input logic [1:0] sid);
        logic [15:0] a;
        a        = 16'($urandom);
        a[15]    = 1'b1;
        a[14:13] = sid;
        return a;
    endfunction

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK); idle_inputs(); #1; model_step();
        end
    endtask

    task automatic test_reset();
        @(negedge CLK); #1;
        n_checks++;
        if (obs_vec() !== 57'd0) $display("FAIL reset_idle got=%h exp=0", obs_vec()); else n_pass++;
        model_step();
        @(negedge CLK); set_master(0, 1'b1, 1'b0, 16'h9005, 32'h1234_5678); #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_req got=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
        model_step();
        @(negedge CLK); #1;
        n_checks++;
        if (bus.M0_GNT !== 1'b1) $display("FAIL reset_pre_gnt got=%b exp=1", bus.M0_GNT); else n_pass++;
        model_step();
        @(negedge CLK); RST = 1'b1; model_reset(); #1;
        n_checks++;
        if (obs_vec() !== 57'd0) $display("FAIL reset_async got=%h exp=0", obs_vec()); else n_pass++;
        @(negedge CLK); RST = 1'b0; idle_inputs(); #1;
        n_checks++;
        if (obs_vec() !== 57'd0) $display("FAIL reset_release got=%h exp=0", obs_vec()); else n_pass++;
        model_step();
    endtask

    task automatic test_single_grant();
        logic [31:0] d;
        d = $urandom;
        @(negedge CLK); set_master(0, 1'b1, 1'b0, 16'h9005, d); #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL single_c0 got=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
        model_step();
        @(negedge CLK); #1;
        n_checks++;
        if ({bus.M0_GNT, bus.M1_GNT, bus.SEL, bus.HADDR} !== {1'b1, 1'b0, 3'b001, 16'h9005})
            $display("FAIL single_grant got=%b%b %b %h exp=10 001 9005", bus.M0_GNT, bus.M1_GNT, bus.SEL, bus.HADDR);
        else n_pass++;
        model_step();
        @(negedge CLK); bus.M0_REQ = 1'b0; #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL single_drop got=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
        model_step();
        @(negedge CLK); #1;
        n_checks++;
        if ({bus.M0_GNT, bus.SEL} !== 4'b0000) $display("FAIL single_idle got=%b %b exp=0 000", bus.M0_GNT, bus.SEL); else n_pass++;
        model_step();
        settle(2);
    endtask

    task automatic test_round_robin();
        int         cnt [2];
        int         order [$];
        bit         handover_ok;
        logic [1:0] prev_g, cur_g;
        int         o0, o1, o2;
        cnt[0] = 0; cnt[1] = 0; handover_ok = 1'b1; prev_g = 2'b00;
        @(negedge CLK); RST = 1'b1; model_reset(); idle_inputs();
        @(negedge CLK); RST = 1'b0; model_step();
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            set_master(0, cnt[0] != 3, 1'b0, rand_addr(2'($urandom_range(0, 2))), $urandom);
            set_master(1, cnt[1] != 3, 1'b0, rand_addr(2'($urandom_range(0, 2))), $urandom);
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); else n_pass++;
            cur_g = {bus.M1_GNT, bus.M0_GNT};
            if (prev_g != 2'b00 && cur_g != 2'b00 && prev_g != cur_g) handover_ok = 1'b0;
            if (cur_g[0] && !prev_g[0]) order.push_back(0);
            if (cur_g[1] && !prev_g[1]) order.push_back(1);
            for (int m = 0; m < 2; m++) cnt[m] = cur_g[m] ? cnt[m] + 1 : 0;
            prev_g = cur_g;
            model_step();
        end
        o0 = (order.size() > 0) ? order[0] : -1;
        o1 = (order.size() > 1) ? order[1] : -1;
        o2 = (order.size() > 2) ? order[2] : -1;
        n_checks++;
        if (o0 != 0 || o1 != 1 || o2 != 0) $display("FAIL rr_order got=%0d,%0d,%0d exp=0,1,0", o0, o1, o2); else n_pass++;
        n_checks++;
        if (!handover_ok) $display("FAIL rr_idle_gap got=direct_handover exp=idle_between"); else n_pass++;
        settle(3);
    endtask

    task automatic test_lock();
        @(negedge CLK); set_master(0, 1'b1, 1'b1, rand_addr(2'd2), $urandom); #1; model_step();
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            set_master(0, 1'b0, 1'b1, rand_addr(2'd2), $urandom);
            set_master(1, 1'b1, 1'b0, rand_addr(2'd0), $urandom);
            #1;
            n_checks++;
            if ({bus.M0_GNT, bus.M1_GNT, bus.MLOCK} !== 3'b101 || obs_vec() !== exp_vec())
                $display("FAIL lock_hold cyc=%0d got=%b%b%b exp=101 vec=%h", c, bus.M0_GNT, bus.M1_GNT, bus.MLOCK, obs_vec());
            else n_pass++;
            model_step();
        end
        @(negedge CLK); bus.M0_LOCK = 1'b0; #1; model_step();
        @(negedge CLK); #1;
        n_checks++;
        if ({bus.M0_GNT, bus.M1_GNT, bus.SEL} !== 5'b00000) $display("FAIL lock_release got=%b%b %b exp=00 000", bus.M0_GNT, bus.M1_GNT, bus.SEL); else n_pass++;
        model_step();
        @(negedge CLK); #1;
        n_checks++;
        if ({bus.M0_GNT, bus.M1_GNT} !== 2'b01 || obs_vec() !== exp_vec()) $display("FAIL lock_next_owner got=%b%b exp=01", bus.M0_GNT, bus.M1_GNT); else n_pass++;
        model_step();
        settle(3);
    endtask

    task automatic test_timeout();
        int own_cnt;
        bit seen;
        own_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            set_master(1, 1'b1, 1'b0, rand_addr(2'd1), $urandom);
            bus.HREADY = 1'bz; bus.HRESP = RESP_OKAY;
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL timeout_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); else n_pass++;
            if (bus.M1_GNT) own_cnt++;
            if (!bus.M0_GNT && !bus.M1_GNT && bus.M_HRESP == 2'b01 && bus.M_HREADY) seen = 1'b1;
            model_step();
        end
        n_checks++;
        if (!seen || own_cnt != 16) $display("FAIL timeout_abort got=seen%0d own%0d exp=seen1 own16", seen, own_cnt); else n_pass++;
        @(negedge CLK); idle_inputs(); #1;
        n_checks++;
        if ({bus.M_HRESP, bus.M_HREADY, bus.M1_GNT} !== 4'b0000) $display("FAIL timeout_one_cycle got=%b%b%b exp=0000", bus.M_HRESP, bus.M_HREADY, bus.M1_GNT); else n_pass++;
        model_step();
        settle(2);

        // Timeout and retry limit reached on the same cycle
        own_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            set_master(0, 1'b1, 1'b0, rand_addr(2'd0), $urandom);
            bus.HREADY = 1'bz; bus.HRESP = (own_cnt >= 12) ? RESP_RETRY : RESP_OKAY;
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL both_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); else n_pass++;
            if (bus.M0_GNT) own_cnt++;
            if (!bus.M0_GNT && !bus.M1_GNT && bus.M_HRESP == 2'b01 && bus.M_HREADY) seen = 1'b1;
            model_step();
        end
        n_checks++;
        if (!seen || own_cnt != 16) $display("FAIL both_abort got=seen%0d own%0d exp=seen1 own16", seen, own_cnt); else n_pass++;
        @(negedge CLK); idle_inputs(); #1;
        n_checks++;
        if ({bus.M_HRESP, bus.M_HREADY} !== 3'b000) $display("FAIL both_single_abort got=%b%b exp=000", bus.M_HRESP, bus.M_HREADY); else n_pass++;
        model_step();
        settle(2);
    endtask

    task automatic test_retry();
        int own_cnt, aborts;
        bit seen;
        own_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            set_master(0, 1'b1, 1'b0, rand_addr(2'd1), $urandom);
            bus.HREADY = 1'b1; bus.HRESP = RESP_RETRY;
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL retry_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); else n_pass++;
            if (bus.M0_GNT) own_cnt++;
            if (!bus.M0_GNT && bus.M_HRESP == 2'b01 && bus.M_HREADY) seen = 1'b1;
            model_step();
        end
        n_checks++;
        if (!seen || own_cnt != 4) $display("FAIL retry_abort got=seen%0d own%0d exp=seen1 own4", seen, own_cnt); else n_pass++;
        settle(3);

        own_cnt = 0; aborts = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            set_master(0, 1'b1, 1'b1, rand_addr(2'd1), $urandom);
            bus.HREADY = 1'b1; bus.HRESP = RESP_RETRY;
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL retry_lock_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); else n_pass++;
            if (bus.M0_GNT) own_cnt++;
            if (bus.M_HRESP == 2'b01) aborts++;
            model_step();
        end
        n_checks++;
        if (aborts != 0 || own_cnt != 7) $display("FAIL retry_locked got=aborts%0d own%0d exp=aborts0 own7", aborts, own_cnt); else n_pass++;
        settle(3);
    endtask

    task automatic test_decode_err();
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            set_master(1, 1'b1, 1'b0, 16'hE000, $urandom);
            bus.HREADY = 1'b0; bus.HRESP = RESP_OKAY;
            #1;
            if (c >= 1) begin
                n_checks++;
                if ({bus.M1_GNT, bus.SEL, bus.M_HRESP, bus.M_HREADY} !== {1'b1, 3'b000, 2'b01, 1'b1})
                    $display("FAIL decode_err cyc=%0d got=%b %b %b %b exp=1 000 01 1", c, bus.M1_GNT, bus.SEL, bus.M_HRESP, bus.M_HREADY);
                else n_pass++;
            end
            model_step();
        end
        settle(3);
    endtask

    task automatic test_random();
        int r;
        bit bad_ready;
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            set_master(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 16'($urandom), $urandom);
            set_master(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 16'($urandom), $urandom);
            bad_ready = ((c / 250) % 2 == 1) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 1);
            bus.HREADY = !bad_ready ? 1'b1 : (r == 0 ? 1'b0 : 1'bz);
            bus.HRESP  = ($urandom_range(0, 3) == 0) ? RESP_RETRY :
                         (($urandom_range(0, 7) == 0) ? RESP_ERROR : RESP_OKAY);
            if ($urandom_range(0, 199) == 0) begin RST = 1'b1; model_reset(); end
            else RST = 1'b0;
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); else n_pass++;
            if (!RST) model_step();
        end
        @(negedge CLK); RST = 1'b0; idle_inputs(); #1; model_step();
        settle(3);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_step();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_lock();
        test_timeout();
        test_retry();
        test_decode_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
